maxpool_slb_ctrl: RTL
=====================

# maxpool_slb_ctrl

Sequencer for the 2x2, stride-2 max-pooling stage. It accepts a raster-order pixel stream for one feature-map frame. It drives the sliding line buffer's shift enable and row-parity select, and issues one registered window-valid strobe per completed 2x2 window, with downstream backpressure. It sits between the convolution output stream and the max-pool compare/line-buffer datapath. It carries no pixel data, only control.

## Interface
- CNT_W, 5: width of frame dimension inputs and row/column counters.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start request; sampled only in IDLE.
- cfg_width  in  CNT_W  frame width in pixels; latched on accepted start.
- cfg_height  in  CNT_W  frame height in pixels; latched on accepted start.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  controller accepts a pixel this cycle.
- slb_shift  out  1  line-buffer shift enable; equals accept = in_valid & in_ready (combinational).
- row_odd  out  1  parity of current input row; 1 selects compare-with-stored-row in the buffer.
- win_valid  out  1  2x2 window complete; datapath max result is valid.
- win_row  out  CNT_W-1  output row index of the window (row>>1).
- win_col  out  CNT_W-1  output column index of the window (col>>1).
- out_ready  in  1  downstream consumes the window this cycle.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.

## Operation
- States: IDLE, RUN, FLUSH, DONE. All outputs are registered except in_ready and slb_shift.
- IDLE:
  - start=1 with cfg_width>=2 and cfg_height>=2 latches W and H, clears row/col, and goes to RUN.
  - start with either dimension <2 is ignored; the controller stays in IDLE.
- RUN:
  - in_ready = !(win_valid & !out_ready).
  - Each accept increments col. At col==W-1, col wraps to 0 and row increments.
  - row_odd = row[0], updated with row.
- Window completion:
  - An accept with row[0]==1 and col[0]==1 sets win_valid on the next edge, with win_row=row>>1 and win_col=col>>1.
  - win_valid holds, with win_row/win_col stable, until out_ready=1, then clears on the next edge.
- Odd dimensions use floor semantics. The last column or row is accepted and shifted but produces no window. Window count = (W>>1)*(H>>1).
- Frame end and DONE:
  - Accepting the pixel at row==H-1, col==W-1 moves RUN to FLUSH. in_ready=0 in FLUSH.
  - FLUSH moves to DONE when !win_valid, or when win_valid & out_ready.
  - DONE lasts one cycle with frame_done=1, then returns to IDLE. row, col and row_odd clear to 0.
- start outside IDLE is ignored. cfg_* changes after the latch have no effect.
- Reset values: in_ready 0, slb_shift 0, row_odd 0, win_valid 0, win_row 0, win_col 0, busy 0, frame_done 0. State is IDLE.
- Reset mid-frame: everything returns to reset values immediately (async). A pending window is dropped. No frame_done is issued.

## Timing
- Accepted start at edge t: state is RUN at t+1, and in_ready can be 1 from t+1.
- Window latency: completing pixel accepted at edge t gives win_valid=1 during cycle t+1.
- Completing pixels are at least 2 accepts apart. win_valid & out_ready in the same cycle as an accept is legal, so a new strobe never overwrites an unconsumed one.
- Frame end with no backpressure: last pixel accepted at edge t, then frame_done=1 during cycle t+2 and busy=0 at t+3. This holds for both even and odd dimensions.
- Each cycle of out_ready low while a window is pending delays frame_done by one cycle.

## Test plan
- 4x4 frame, in_valid and out_ready held high:
  - 16 accepts in 16 consecutive cycles.
  - win_valid pulses 4 times with (row,col) = (0,0), (0,1), (1,0), (1,1), one cycle after pixels 5, 7, 13 and 15 (0-based).
  - frame_done 2 cycles after the last accept.
- Backpressure: 4x4 frame with out_ready=0 for 3 cycles after the first win_valid.
  - in_ready=0 for those 3 cycles.
  - win_valid and its indices stay stable.
  - No pixel is lost; the count still reaches 16 accepts and 4 windows.
- Odd dimensions: W=5, H=3.
  - 15 accepts and exactly 2 windows, at (0,0) and (0,1).
  - row_odd toggles after accepts 5 and 10.
  - frame_done arrives 2 cycles after the last accept.
- Invalid and redundant start:
  - start with cfg_width=1 keeps busy=0 and in_ready=0.
  - start asserted during RUN leaves the counters unchanged.
- Reset mid-frame: assert rst_n=0 while win_valid=1 after 7 accepts.
  - All outputs go to 0 immediately.
  - After release, a fresh 2x2 frame produces one window at (0,0).

Source files
------------

// File: rtl/maxpool_slb_ctrl.sv
// Control sequencer for the 2x2 stride-2 max-pool stage: counts raster pixels,
// drives the line-buffer shift/row-parity controls and issues one strobe per 2x2 window.
module maxpool_slb_ctrl #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_height,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             slb_shift,
  output logic             row_odd,
  output logic             win_valid,
  output logic [CNT_W-2:0] win_row,
  output logic [CNT_W-2:0] win_col,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] DIM_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] w_last_reg;
  logic [CNT_W-1:0] h_last_reg;
  logic [CNT_W-1:0] row_reg;
  logic [CNT_W-1:0] col_reg;

  logic cfg_ok;
  logic accept;
  logic col_last;
  logic row_last;
  logic win_done;
  logic win_take;

  assign cfg_ok    = (cfg_width >= DIM_MIN) && (cfg_height >= DIM_MIN);
  // Stall input only while a finished window is waiting on downstream.
  assign in_ready  = (state_reg == RUN) && !(win_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign slb_shift = accept;
  assign col_last  = (col_reg == w_last_reg);
  assign row_last  = (row_reg == h_last_reg);
  assign win_done  = accept && row_reg[0] && col_reg[0];
  assign win_take  = win_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      w_last_reg <= '0;
      h_last_reg <= '0;
      row_reg    <= '0;
      col_reg    <= '0;
      row_odd    <= 1'b0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && cfg_ok) begin
            w_last_reg <= cfg_width - ONE;
            h_last_reg <= cfg_height - ONE;
            row_reg    <= '0;
            col_reg    <= '0;
            row_odd    <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (win_done) begin
            win_valid <= 1'b1;
            win_row   <= row_reg[CNT_W-1:1];
            win_col   <= col_reg[CNT_W-1:1];
          end else if (win_take) begin
            win_valid <= 1'b0;
          end
          if (accept) begin
            if (col_last) begin
              col_reg <= '0;
              // Row stays on the last row so row_odd holds until the frame closes.
              if (row_last) begin
                state_reg <= FLUSH;
              end else begin
                row_reg <= row_reg + ONE;
                row_odd <= ~row_reg[0];
              end
            end else begin
              col_reg <= col_reg + ONE;
            end
          end
        end
        FLUSH: begin
          if (!win_valid || out_ready) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          row_reg    <= '0;
          col_reg    <= '0;
          row_odd    <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
